// File: rtl/uart_alu_pkg.sv
// Definitions shared along the UART-to-ALU path: collector FSM encoding,
// default byte/opcode widths and the ALU opcode constants.
package uart_alu_pkg;

    localparam int DEFAULT_NB_DATA   = 8;
    localparam int DEFAULT_NB_OPCODE = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } frame_state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte timer: counts idle cycles while enabled and flags the cycle in
// which the count reaches TIMEOUT_CYCLES-1 without a restart.
module rx_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || restart || !enable) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // A restart in the expiry cycle wins, so it masks the expire flag.
    assign expire = enable && !restart && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rx_frame_collector.sv
// Assembles N operands plus one opcode byte from the UART RX strobe and
// hands the frame to the ALU; optional inter-byte timeout via RX_FRAME_TIMEOUT_EN.
module rx_frame_collector
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA        = DEFAULT_NB_DATA,
    parameter int NB_OPERAND     = 16,
    parameter int N_OPERANDS     = 2,
    parameter int NB_OPCODE      = DEFAULT_NB_OPCODE,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NB_DATA-1:0]             i_data,
    input  logic                           i_done_data,
    input  logic                           i_alu_ready,
    output logic [N_OPERANDS*NB_OPERAND-1:0] o_operands,
    output logic [NB_OPCODE-1:0]           o_op,
    output logic                           o_valid,
    output logic                           o_overrun,
    output logic                           o_timeout
);

    localparam int BPO           = NB_OPERAND / NB_DATA;
    localparam int OPERAND_BYTES = N_OPERANDS * BPO;
    localparam int FRAME_BYTES   = OPERAND_BYTES + 1;
    localparam int CNT_W         = $clog2(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    generate
        if (NB_OPERAND % NB_DATA != 0) begin : g_bad_operand_width
            $error("NB_OPERAND must be an integer multiple of NB_DATA");
        end
        if (NB_OPCODE > NB_DATA) begin : g_bad_opcode_width
            $error("NB_OPCODE must not exceed NB_DATA");
        end
        if (N_OPERANDS < 1) begin : g_bad_operand_count
            $error("N_OPERANDS must be at least 1");
        end
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    frame_state_t     state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next, store_idx;
    logic             store, overrun_next, timeout_next, expire;

`ifdef RX_FRAME_TIMEOUT_EN
    rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (i_clk),
        .rst    (i_rst),
        .enable (state == COLLECT),
        .restart(i_done_data),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        cnt_next     = cnt;
        store        = 1'b0;
        store_idx    = cnt;
        overrun_next = 1'b0;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (i_done_data) begin
                    store      = 1'b1;
                    store_idx  = '0;
                    cnt_next   = CNT_W'(1);
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (i_done_data) begin
                    store = 1'b1;
                    if (cnt == LAST_IDX) begin
                        cnt_next   = '0;
                        next_state = HOLD;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else if (expire) begin
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                    next_state   = IDLE;
                end
            end
            HOLD: begin
                // Accept and a new strobe together start the next frame at once.
                if (i_alu_ready) begin
                    if (i_done_data) begin
                        store      = 1'b1;
                        store_idx  = '0;
                        cnt_next   = CNT_W'(1);
                        next_state = COLLECT;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (i_done_data) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                cnt_next   = '0;
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt        <= '0;
            o_operands <= '0;
            o_op       <= '0;
            o_valid    <= 1'b0;
            o_overrun  <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            o_valid   <= (next_state == HOLD);
            o_overrun <= overrun_next;
            o_timeout <= timeout_next;
            // Byte b of the frame sits at bit b*NB_DATA, which is LSB-first per operand.
            if (store) begin
                for (int b = 0; b < OPERAND_BYTES; b++) begin
                    if (store_idx == CNT_W'(b)) begin
                        o_operands[b*NB_DATA +: NB_DATA] <= i_data;
                    end
                end
                if (store_idx == LAST_IDX) begin
                    o_op <= i_data[NB_OPCODE-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_collector.sv
// Self-checking bench for rx_frame_collector; the timeout scenario follows
// whether RX_FRAME_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_rx_frame_collector;

    localparam int T_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        done;
    logic        ready;
    logic [31:0] operands;
    logic [5:0]  op;
    logic        valid, overrun, timeout;

    logic [7:0]  w_data;
    logic        w_done;
    logic        w_ready;
    logic [95:0] w_operands;
    logic [5:0]  w_op;
    logic        w_valid, w_overrun, w_timeout;

    int errors = 0;
    int checks = 0;

    rx_frame_collector #(
        .NB_DATA(8), .NB_OPERAND(16), .N_OPERANDS(2), .NB_OPCODE(6), .TIMEOUT_CYCLES(T_CYC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_done_data(done), .i_alu_ready(ready),
        .o_operands(operands), .o_op(op), .o_valid(valid), .o_overrun(overrun), .o_timeout(timeout)
    );

    rx_frame_collector #(
        .NB_DATA(8), .NB_OPERAND(32), .N_OPERANDS(3), .NB_OPCODE(6), .TIMEOUT_CYCLES(T_CYC)
    ) dut_wide (
        .i_clk(clk), .i_rst(rst), .i_data(w_data), .i_done_data(w_done), .i_alu_ready(w_ready),
        .o_operands(w_operands), .o_op(w_op), .o_valid(w_valid), .o_overrun(w_overrun),
        .o_timeout(w_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data = b;
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // Reference: operand k is the little-endian number formed by its bytes,
    // placed at k*nb_operand; the opcode is the last byte modulo 64.
    function automatic logic [95:0] model_operands(input logic [7:0] fb[$], input int n_ops,
                                                   input int nb_operand);
        logic [95:0] result;
        int bpo;
        result = '0;
        bpo = nb_operand / 8;
        for (int k = 0; k < n_ops; k++) begin
            longint unsigned value;
            value = 0;
            for (int j = 0; j < bpo; j++) begin
                value += longint'(fb[k*bpo + j]) * (longint'(1) << (8*j));
            end
            result |= 96'(value) << (k*nb_operand);
        end
        return result;
    endfunction

    function automatic logic [5:0] model_opcode(input logic [7:0] fb[$]);
        return 6'(fb[fb.size()-1] % 64);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        done = 1'b1;
        data = 8'hC3;
        tick();
        tick();
        done = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (operands !== 32'h0) begin errors++; $display("[TB] FAIL reset_operands: got %h expected 0", operands); end
        checks++; if (op !== 6'h0) begin errors++; $display("[TB] FAIL reset_op: got %h expected 0", op); end
        checks++; if ({overrun, timeout} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 00", {overrun, timeout}); end
        checks++; if ({w_valid, w_operands, w_op, w_overrun, w_timeout} !== '0) begin errors++; $display("[TB] FAIL reset_wide: got nonzero expected all zero"); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] fb[$];
        fb = {8'h34, 8'h12, 8'h78, 8'h56, 8'h20};
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(fb[i]);
            checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: byte %0d got %b expected 0", i, valid); end
        end
        send_byte(fb[4]);
        checks++; if (operands !== 32'h5678_1234) begin errors++; $display("[TB] FAIL basic_operands: got %h expected 56781234", operands); end
        checks++; if (op !== 6'h20) begin errors++; $display("[TB] FAIL basic_op: got %h expected 20", op); end
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", valid); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_accept: got %b expected 0", valid); end
    endtask

    task automatic test_overrun();
        logic [7:0] fb[$];
        logic [31:0] exp_ops;
        fb = {};
        for (int i = 0; i < 5; i++) fb.push_back(8'($urandom));
        exp_ops = model_operands(fb, 2, 16)[31:0];
        ready = 1'b0;
        foreach (fb[i]) send_byte(fb[i]);
        send_byte(8'hAA);
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_pulse: got %b expected 1", overrun); end
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL overrun_valid: got %b expected 1", valid); end
        tick();
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_width: got %b expected 0", overrun); end
        checks++; if (operands !== exp_ops) begin errors++; $display("[TB] FAIL overrun_operands: got %h expected %h", operands, exp_ops); end
        checks++; if (op !== model_opcode(fb)) begin errors++; $display("[TB] FAIL overrun_op: got %h expected %h", op, model_opcode(fb)); end
        ready = 1'b1;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL overrun_accept: got %b expected 0", valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fb[$];
        logic [7:0] nxt[$];
        ready = 1'b0;
        fb = {};
        for (int i = 0; i < 5; i++) fb.push_back(8'($urandom));
        foreach (fb[i]) send_byte(fb[i]);
        ready = 1'b1;
        send_byte(8'h11);
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept: got %b expected 0", valid); end
        nxt = {8'h00, 8'h22, 8'h00, 8'h05};
        foreach (nxt[i]) send_byte(nxt[i]);
        checks++; if (operands !== 32'h0022_0011) begin errors++; $display("[TB] FAIL b2b_operands: got %h expected 00220011", operands); end
        checks++; if (op !== 6'h05) begin errors++; $display("[TB] FAIL b2b_op: got %h expected 05", op); end
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid: got %b expected 1", valid); end
        for (int f = 0; f < 3; f++) begin
            fb = {};
            for (int i = 0; i < 5; i++) fb.push_back(8'($urandom));
            for (int i = 0; i < 5; i++) begin
                send_byte(fb[i]);
                checks++; if (valid !== (i == 4)) begin errors++; $display("[TB] FAIL stream_valid: frame %0d byte %0d got %b expected %b", f, i, valid, (i == 4)); end
            end
            checks++; if (operands !== model_operands(fb, 2, 16)[31:0]) begin errors++; $display("[TB] FAIL stream_operands: got %h expected %h", operands, model_operands(fb, 2, 16)[31:0]); end
            checks++; if (op !== model_opcode(fb)) begin errors++; $display("[TB] FAIL stream_op: got %h expected %h", op, model_opcode(fb)); end
        end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got %b expected 0", valid); end
    endtask

    task automatic test_timeout();
        logic [7:0] fb[$];
        int pulses;
        int pulse_at;
        logic saw_valid;
        ready = 1'b1;
        fb = {};
        for (int i = 0; i < 5; i++) fb.push_back(8'($urandom));
        send_byte(fb[0]);
        send_byte(fb[1]);
        pulses = 0;
        pulse_at = -1;
        saw_valid = 1'b0;
        for (int i = 1; i <= T_CYC + 4; i++) begin
            tick();
            if (timeout === 1'b1) begin pulses++; pulse_at = i; end
            if (valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++; if (saw_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_no_valid: got %b expected 0", saw_valid); end
`ifdef RX_FRAME_TIMEOUT_EN
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL timeout_pulses: got %0d expected 1", pulses); end
        checks++; if (pulse_at != T_CYC) begin errors++; $display("[TB] FAIL timeout_cycle: got %0d expected %0d", pulse_at, T_CYC); end
        foreach (fb[i]) send_byte(fb[i]);
`else
        checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL timeout_pulses: got %0d expected 0", pulses); end
        for (int i = 2; i < 5; i++) send_byte(fb[i]);
`endif
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL timeout_next_valid: got %b expected 1", valid); end
        checks++; if (operands !== model_operands(fb, 2, 16)[31:0]) begin errors++; $display("[TB] FAIL timeout_next_operands: got %h expected %h", operands, model_operands(fb, 2, 16)[31:0]); end
        tick();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] fb[$];
        ready = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(1, 255)));
        rst = 1'b1;
        send_byte(8'h99);
        checks++; if ({valid, operands, op, overrun, timeout} !== '0) begin errors++; $display("[TB] FAIL midreset_outputs: got %b/%h/%h expected all zero", valid, operands, op); end
        rst = 1'b0;
        fb = {};
        for (int i = 0; i < 5; i++) fb.push_back(8'($urandom));
        foreach (fb[i]) send_byte(fb[i]);
        checks++; if (operands !== model_operands(fb, 2, 16)[31:0]) begin errors++; $display("[TB] FAIL midreset_operands: got %h expected %h", operands, model_operands(fb, 2, 16)[31:0]); end
        checks++; if (op !== model_opcode(fb)) begin errors++; $display("[TB] FAIL midreset_op: got %h expected %h", op, model_opcode(fb)); end
        tick();
    endtask

    task automatic test_opcode_mask();
        logic [7:0] fb[$];
        fb = {8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
        ready = 1'b1;
        foreach (fb[i]) send_byte(fb[i]);
        checks++; if (op !== 6'h3F) begin errors++; $display("[TB] FAIL opcode_mask: got %h expected 3f", op); end
        tick();
    endtask

    task automatic test_wide();
        logic [7:0] fb[$];
        logic [95:0] exp_ops;
        fb = {};
        for (int i = 0; i < 13; i++) fb.push_back(8'($urandom));
        exp_ops = model_operands(fb, 3, 32);
        w_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            w_data = fb[i];
            w_done = 1'b1;
            tick();
            w_done = 1'b0;
            checks++; if (w_valid !== (i == 12)) begin errors++; $display("[TB] FAIL wide_valid: byte %0d got %b expected %b", i, w_valid, (i == 12)); end
        end
        checks++; if (w_operands !== exp_ops) begin errors++; $display("[TB] FAIL wide_operands: got %h expected %h", w_operands, exp_ops); end
        checks++; if (w_op !== model_opcode(fb)) begin errors++; $display("[TB] FAIL wide_op: got %h expected %h", w_op, model_opcode(fb)); end
        tick();
        checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL wide_accept: got %b expected 0", w_valid); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            logic [7:0] fb[$];
            logic [31:0] exp_ops;
            int hold;
            fb = {};
            for (int i = 0; i < 5; i++) fb.push_back(8'($urandom));
            exp_ops = model_operands(fb, 2, 16)[31:0];
            ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                send_byte(fb[i]);
            end
            checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL rand_valid: frame %0d got %b expected 1", f, valid); end
            checks++; if (operands !== exp_ops) begin errors++; $display("[TB] FAIL rand_operands: got %h expected %h", operands, exp_ops); end
            checks++; if (op !== model_opcode(fb)) begin errors++; $display("[TB] FAIL rand_op: got %h expected %h", op, model_opcode(fb)); end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                logic extra;
                extra = 1'($urandom_range(0, 1));
                if (extra) send_byte(8'($urandom));
                else tick();
                checks++; if (overrun !== extra) begin errors++; $display("[TB] FAIL rand_overrun: got %b expected %b", overrun, extra); end
                checks++; if (operands !== exp_ops) begin errors++; $display("[TB] FAIL rand_hold_operands: got %h expected %h", operands, exp_ops); end
            end
            ready = 1'b1;
            tick();
            checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL rand_accept: got %b expected 0", valid); end
            ready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        done = 1'b0;
        data = 8'h00;
        ready = 1'b0;
        w_data = 8'h00;
        w_done = 1'b0;
        w_ready = 1'b0;
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
        test_opcode_mask();
        test_wide();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_frame_collector.md
# rx_frame_collector

Parametrised byte-to-operand frame assembler between the UART receiver and the ALU. It collects a fixed-length frame of N operands, each several bytes wide, followed by one opcode byte, from the RX byte strobe. It presents the complete frame to the ALU with a valid/ready handshake. It also reports overrun and, optionally, inter-byte timeout.

## Interface
- NB_DATA, 8, UART byte width
- NB_OPERAND, 16, operand width; integer multiple of NB_DATA
- N_OPERANDS, 2, operands per frame, ≥1
- NB_OPCODE, 6, opcode width; ≤ NB_DATA
- TIMEOUT_CYCLES, 50000, inter-byte timeout in i_clk cycles, ≥2 (used only with RX_FRAME_TIMEOUT_EN)

Ports:
- i_clk  in  1  single clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_data  in  NB_DATA  byte from UART RX
- i_done_data  in  1  one-cycle strobe, i_data valid
- i_alu_ready  in  1  ALU accepts frame
- o_operands  out  N_OPERANDS*NB_OPERAND  operand k at [k*NB_OPERAND +: NB_OPERAND]
- o_op  out  NB_OPCODE  opcode
- o_valid  out  1  frame complete, held until accepted
- o_overrun  out  1  one-cycle pulse, byte dropped
- o_timeout  out  1  one-cycle pulse, partial frame discarded (constant 0 without macro)

## Operation
- Derived values:
  - BPO = NB_OPERAND/NB_DATA
  - FRAME_BYTES = N_OPERANDS*BPO + 1
  - byte counter width = $clog2(FRAME_BYTES)
- Byte order: operand 0 first. Within an operand, least significant byte first. Byte j of operand k lands at bits [k*NB_OPERAND + j*NB_DATA +: NB_DATA]. The last frame byte is the opcode; o_op takes i_data[NB_OPCODE-1:0].
- Bytes are written directly into the output registers. Outputs are not cleared on accept; they are meaningful only while o_valid=1.
- FSM states:
  - IDLE: counter=0. On strobe, store byte 0, set counter=1, go to COLLECT.
  - COLLECT: on strobe, store byte at counter index and increment. If the stored byte is the opcode (counter=FRAME_BYTES-1), clear the counter and go to HOLD.
  - HOLD: o_valid=1. When i_alu_ready=1, go to IDLE. A strobe without accept drops the byte and pulses o_overrun; outputs are unchanged.
- Simultaneous accept and strobe in HOLD: the frame is accepted and the byte is stored as byte 0 of the next frame. The next state is COLLECT, with no overrun.
- Reset, any state including mid-frame: state=IDLE, counter=0, timer=0, and all outputs (o_operands, o_op, o_valid, o_overrun, o_timeout) are 0. The partial frame is discarded.
- Illegal parameters (NB_OPERAND % NB_DATA ≠ 0, NB_OPCODE > NB_DATA) are caught by an elaboration-time check.

## Timing
- All outputs are registered.
- The opcode strobe at cycle t gives o_valid=1 at t+1, with o_operands and o_op stable from t+1.
- o_valid falls the cycle after the handshake cycle (o_valid & i_alu_ready).
- Minimum frame-to-frame: a back-to-back strobe every cycle is supported. The valid-to-next-valid interval is FRAME_BYTES cycles when i_alu_ready=1.
- o_overrun and o_timeout last exactly one cycle each and appear the cycle after the causing event.
- i_done_data while i_rst=1 is ignored.

## Configuration
- RX_FRAME_TIMEOUT_EN defined:
  - An inter-byte timer runs only in COLLECT and restarts on every strobe.
  - When the timer reaches TIMEOUT_CYCLES-1 with no strobe, the block goes to IDLE, sets counter=0, and pulses o_timeout.
  - A strobe in the expiry cycle wins: the byte is stored and the timer restarts.
  - HOLD never times out.
- RX_FRAME_TIMEOUT_EN undefined: no timer logic; o_timeout is tied to 0 and COLLECT waits indefinitely.

## Structure
- Shared package uart_alu_pkg holds:
  - the FSM state encoding (IDLE/COLLECT/HOLD)
  - default widths (NB_DATA, NB_OPCODE)
  - the opcode constants already shared with the ALU
- One sub-module: rx_timeout_timer, with restart/enable inputs and an expire pulse. It is instantiated only under RX_FRAME_TIMEOUT_EN.
- The counter, byte steering and FSM stay in the top module.

## Test plan
- Defaults, i_alu_ready=1, bytes 0x34,0x12,0x78,0x56,0x20 → one cycle after the 5th strobe: o_operands=0x5678_1234, o_op=0x20, o_valid=1 for one cycle.
- i_alu_ready=0 after a complete frame; extra byte 0xAA → o_valid held, one o_overrun pulse, outputs unchanged. Raising ready then accepts the original frame.
- In HOLD, i_alu_ready=1 and strobe 0x11 in the same cycle → frame accepted, no overrun. Next frame 0x11,0x00,0x22,0x00,0x05 → o_operands=0x0022_0011, o_op=0x05.
- RX_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=16: 2 bytes, then 16 idle cycles → one o_timeout pulse, no o_valid. A following clean 5-byte frame is assembled correctly.
- i_rst=1 for one cycle after 3 bytes → all outputs 0 the next cycle. A following full frame gives correct operands.
- Opcode byte 0xFF, NB_OPCODE=6 → o_op=0x3F. Re-run scenario 1 with NB_OPERAND=32, N_OPERANDS=3 (13 bytes) → operands placed per the byte-order rule.
